// File: rtl/registers_bank_param.sv
// rtl/registers_bank_param.sv - parametrised integer register file with built-in clear sequencer
//
// Purpose:
//   Register file between decode (read selects) and writeback (write port).
//   x0 is hardwired to zero. A clear sequencer zeroes one entry per cycle after
//   reset or on clear_req, so the storage array itself carries no reset.
//
// Parameters:
//   XLEN   data width in bits
//   NREGS  number of registers (power of two, >= 2)
//   NREAD  number of combinational read ports (>= 1)
//   AW     select width, derived as $clog2(NREGS)
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-low
//   we         write enable
//   sel_in     write register index
//   data_in    write data
//   sel_out    read selects, port k = sel_out[k*AW +: AW]
//   output_rd  read data, port k = output_rd[k*XLEN +: XLEN]
//   clear_req  request a full clear of the bank
//   busy       clear in progress; reads return 0 and writes are ignored
//
// Configuration macro:
//   REGFILE_BYPASS_EN  when defined, a read of the register being written in
//                      the same IDLE cycle returns data_in (write-through).

module registers_bank_param #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    we,
  input  logic [AW-1:0]           sel_in,
  input  logic [XLEN-1:0]         data_in,
  input  logic [NREAD*AW-1:0]     sel_out,
  output logic [NREAD*XLEN-1:0]   output_rd,
  input  logic                    clear_req,
  output logic                    busy
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_idx_q, clr_idx_d;
  logic              busy_q, busy_d;
  logic [XLEN-1:0]   mem_q [NREGS];

  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [XLEN-1:0]   wr_data;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_en     = 1'b0;
    wr_idx    = clr_idx_q;
    wr_data   = '0;
    if (!reset) begin
      state_d   = ST_CLEAR;
      clr_idx_d = '0;
    end else if (state_q == ST_CLEAR) begin
      // One entry zeroed per cycle; the index wraps to 0 as we leave CLEAR.
      wr_en     = 1'b1;
      wr_idx    = clr_idx_q;
      wr_data   = '0;
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == AW'(NREGS - 1)) begin
        state_d = ST_IDLE;
      end
    end else begin
      if (we && (sel_in != '0)) begin
        wr_en   = 1'b1;
        wr_idx  = sel_in;
        wr_data = data_in;
      end
      // A same-cycle write still lands; the clear sweep overwrites it later.
      if (clear_req) begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
      end
    end
    // busy is registered and tracks the state being entered.
    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clock) begin
    state_q   <= state_d;
    clr_idx_q <= clr_idx_d;
    busy_q    <= busy_d;
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign busy = busy_q;

  always_comb begin
    logic [AW-1:0]   rsel;
    logic [XLEN-1:0] rdat;
    output_rd = '0;
    rsel      = '0;
    rdat      = '0;
    for (int k = 0; k < NREAD; k++) begin
      rsel = sel_out[k*AW +: AW];
      rdat = '0;
      // Entry 0 is never read from storage, so it reads 0 even mid-clear.
      if (!busy_q && (rsel != '0)) begin
        rdat = mem_q[rsel];
`ifdef REGFILE_BYPASS_EN
        if (reset && we && (sel_in != '0) && (sel_in == rsel)) begin
          rdat = data_in;
        end
`endif
      end
      output_rd[k*XLEN +: XLEN] = rdat;
    end
  end

endmodule

// File: tb/tb_registers_bank_param.sv
// tb/tb_registers_bank_param.sv - self-checking bench for registers_bank_param
module tb_registers_bank_param;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  localparam int XLEN2  = 64;
  localparam int NREGS2 = 16;
  localparam int NREAD2 = 3;
  localparam int AW2    = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                   reset, we, clear_req, busy;
  logic [AW-1:0]          sel_in;
  logic [XLEN-1:0]        data_in;
  logic [NREAD*AW-1:0]    sel_out;
  logic [NREAD*XLEN-1:0]  output_rd;

  logic                     reset2, we2, clear_req2, busy2;
  logic [AW2-1:0]           sel_in2;
  logic [XLEN2-1:0]         data_in2;
  logic [NREAD2*AW2-1:0]    sel_out2;
  logic [NREAD2*XLEN2-1:0]  output_rd2;

  registers_bank_param #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clock(clock), .reset(reset), .we(we), .sel_in(sel_in), .data_in(data_in),
    .sel_out(sel_out), .output_rd(output_rd), .clear_req(clear_req), .busy(busy)
  );

  registers_bank_param #(.XLEN(XLEN2), .NREGS(NREGS2), .NREAD(NREAD2)) dut2 (
    .clock(clock), .reset(reset2), .we(we2), .sel_in(sel_in2), .data_in(data_in2),
    .sel_out(sel_out2), .output_rd(output_rd2), .clear_req(clear_req2), .busy(busy2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: register contents plus count of clear cycles still to go.
  logic [XLEN-1:0] m_mem [NREGS];
  int              m_cnt   = 0;
  bit              m_valid = 1'b0;

  always @(posedge clock) begin
    if (reset === 1'b0) begin
      m_cnt   = NREGS;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
        end
      end else begin
        if (we && sel_in != 0) m_mem[sel_in] = data_in;
        if (clear_req) m_cnt = NREGS;
      end
    end
  end

  function automatic logic [XLEN-1:0] m_read(input int k);
    logic [AW-1:0] s;
    s = sel_out[k*AW +: AW];
    if (m_cnt > 0 || s == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (reset && we && sel_in != 0 && sel_in == s) return data_in;
`endif
    return m_mem[s];
  endfunction

  always @(negedge clock) begin
    if (m_valid) begin
      chk("busy", {63'd0, busy}, {63'd0, m_cnt > 0});
      for (int k = 0; k < NREAD; k++)
        chk($sformatf("rd%0d", k), {32'd0, output_rd[k*XLEN +: XLEN]}, {32'd0, m_read(k)});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int idx, input logic [XLEN-1:0] d);
    we = 1'b1; sel_in = AW'(idx); data_in = d;
    step();
    we = 1'b0;
  endtask

  task automatic count_busy(input string name, input int exp);
    int n;
    n = 0;
    while (busy && n < 100) begin
      sel_out = NREAD*AW'($urandom);
      we      = 1'b1;
      sel_in  = AW'($urandom);
      data_in = $urandom;
      step();
      n++;
    end
    we = 1'b0;
    chk(name, 64'(n), 64'(exp));
  endtask

  task automatic wr2(input int idx, input logic [XLEN2-1:0] d);
    we2 = 1'b1; sel_in2 = AW2'(idx); data_in2 = d;
    step();
    we2 = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b0; we = 1'b0; clear_req = 1'b0; sel_in = '0; data_in = '0; sel_out = '0;
    reset2 = 1'b0; we2 = 1'b0; clear_req2 = 1'b0; sel_in2 = '0; data_in2 = '0; sel_out2 = '0;

    repeat (2) step();
    chk("busy_in_reset", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    count_busy("busy_len_after_reset", 32);

    wr(5, 32'hDEADBEEF);
    sel_out[0 +: AW] = 5'd5;
    #1 chk("read_x5", {32'd0, output_rd[0 +: XLEN]}, 64'h00000000DEADBEEF);

    we = 1'b1; sel_in = '0; data_in = 32'hFFFFFFFF; sel_out = '0;
    #1 chk("x0_same_p0", {32'd0, output_rd[0 +: XLEN]}, 64'd0);
    chk("x0_same_p1", {32'd0, output_rd[XLEN +: XLEN]}, 64'd0);
    step();
    we = 1'b0;
    #1 chk("x0_next_p0", {32'd0, output_rd[0 +: XLEN]}, 64'd0);
    chk("x0_next_p1", {32'd0, output_rd[XLEN +: XLEN]}, 64'd0);

    wr(7, 32'hA5A50007);
    we = 1'b1; sel_in = 5'd7; data_in = 32'h12345678; sel_out[AW +: AW] = 5'd7;
`ifdef REGFILE_BYPASS_EN
    #1 chk("bypass_same", {32'd0, output_rd[XLEN +: XLEN]}, 64'h0000000012345678);
`else
    #1 chk("bypass_same", {32'd0, output_rd[XLEN +: XLEN]}, 64'h00000000A5A50007);
`endif
    step();
    we = 1'b0;
    #1 chk("bypass_next", {32'd0, output_rd[XLEN +: XLEN]}, 64'h0000000012345678);

    for (int i = 1; i < NREGS; i++) wr(i, XLEN'(i * 3));
    sel_out = {5'd31, 5'd10};
    #1 chk("fill_x10", {32'd0, output_rd[0 +: XLEN]}, 64'd30);
    chk("fill_x31", {32'd0, output_rd[XLEN +: XLEN]}, 64'd93);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    count_busy("busy_len_clear_req", 32);
    for (int i = 0; i < NREGS; i++) begin
      sel_out = {AW'(i), AW'(i)};
      #1 chk($sformatf("cleared_x%0d", i), {32'd0, output_rd[0 +: XLEN] | output_rd[XLEN +: XLEN]}, 64'd0);
    end

    // Randomized traffic with occasional clear requests.
    for (int c = 0; c < 400; c++) begin
      we        = 1'($urandom_range(0, 1));
      sel_in    = AW'($urandom);
      data_in   = $urandom;
      sel_out   = NREAD*AW'($urandom);
      clear_req = ($urandom_range(0, 63) == 0);
      step();
    end
    clear_req = 1'b0; we = 1'b0;
    n = 0;
    while (busy && n < 100) begin step(); n++; end
    chk("drain_busy", {63'd0, busy}, 64'd0);

    // Reset in the middle of a clear restarts the sweep.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (10) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    count_busy("busy_len_mid_reset", 32);

    // Parametric instance: 16 registers, 3 ports, 64-bit.
    repeat (2) step();
    reset2 = 1'b1;
    n = 0;
    while (busy2 && n < 100) begin step(); n++; end
    chk("p2_busy_len", 64'(n), 64'd16);
    wr2(3, 64'h0123456789ABCDEF);
    wr2(9, 64'hFEDCBA9876543210);
    wr2(14, 64'hCAFEF00D0000BEEF);
    wr2(0, 64'h1111111111111111);
    sel_out2 = {4'd14, 4'd9, 4'd3};
    #1 chk("p2_rd0", output_rd2[0 +: XLEN2], 64'h0123456789ABCDEF);
    chk("p2_rd1", output_rd2[XLEN2 +: XLEN2], 64'hFEDCBA9876543210);
    chk("p2_rd2", output_rd2[2*XLEN2 +: XLEN2], 64'hCAFEF00D0000BEEF);
    sel_out2 = {4'd0, 4'd3, 4'd3};
    #1 chk("p2_same_reg", output_rd2[XLEN2 +: XLEN2], 64'h0123456789ABCDEF);
    chk("p2_x0", output_rd2[2*XLEN2 +: XLEN2], 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
